// File: rtl/r2s_frame_sync_pkg.sv
// rtl/r2s_frame_sync_pkg.sv - shared widths and state encoding for the R2S frame synchronizer
package r2s_frame_sync_pkg;

    localparam int ROW_W_DEF   = 12;
    localparam int FRAME_W_DEF = 16;

    typedef enum logic {
        WAIT_FSYNC = 1'b0,
        IN_FRAME   = 1'b1
    } state_t;

endpackage

// File: rtl/r2s_frame_sync_if.sv
// rtl/r2s_frame_sync_if.sv - control, config and status bundle of r2s_frame_sync
interface r2s_frame_sync_if #(
    parameter int ROW_W   = r2s_frame_sync_pkg::ROW_W_DEF,
    parameter int FRAME_W = r2s_frame_sync_pkg::FRAME_W_DEF
);
    logic               EN;
    logic               R2S_IN;
    logic               FSYNC_IN;
    logic [ROW_W-1:0]   CFG_ROWS;
    logic [ROW_W-1:0]   CFG_ROW_FIRST;
    logic [ROW_W-1:0]   CFG_ROW_LAST;
    logic               ERR_CLR;
    logic               ROW_STROBE;
    logic               FRAME_STROBE;
    logic [ROW_W-1:0]   ROW_CNT;
    logic [FRAME_W-1:0] FRAME_CNT;
    logic               ROW_ERR;
    logic               IN_FRAME;

    modport master (
        output EN, R2S_IN, FSYNC_IN, CFG_ROWS, CFG_ROW_FIRST, CFG_ROW_LAST, ERR_CLR,
        input  ROW_STROBE, FRAME_STROBE, ROW_CNT, FRAME_CNT, ROW_ERR, IN_FRAME
    );

    modport slave (
        input  EN, R2S_IN, FSYNC_IN, CFG_ROWS, CFG_ROW_FIRST, CFG_ROW_LAST, ERR_CLR,
        output ROW_STROBE, FRAME_STROBE, ROW_CNT, FRAME_CNT, ROW_ERR, IN_FRAME
    );

endinterface

// File: rtl/r2s_frame_sync_sync_edge.sv
// rtl/r2s_frame_sync_sync_edge.sv - 2FF synchronizer with registered rising-edge pulse
module sync_edge (
    input  logic CLK,
    input  logic RST,
    input  logic async_in,
    output logic edge_pulse
);

    logic sync1;
    logic sync2;
    logic sync3;
    logic vld1;
    logic vld2;
    logic armed;
    logic edge_q;

    // armed only after a genuine low has been synchronized, so a level that was
    // already high when reset released never looks like a rising edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync3  <= 1'b0;
            vld1   <= 1'b0;
            vld2   <= 1'b0;
            armed  <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync1  <= async_in;
            sync2  <= sync1;
            sync3  <= sync2;
            vld1   <= 1'b1;
            vld2   <= vld1;
            armed  <= armed | (vld2 & ~sync2);
            edge_q <= sync2 & ~sync3 & armed;
        end
    end

    assign edge_pulse = edge_q;

endmodule

// File: rtl/r2s_frame_sync.sv
// rtl/r2s_frame_sync.sv - frame/row sync FSM: gates row strobes, counts rows/frames, flags short or long frames
module r2s_frame_sync
    import r2s_frame_sync_pkg::*;
#(
    parameter int ROW_W   = ROW_W_DEF,
    parameter int FRAME_W = FRAME_W_DEF
) (
    input  logic           CLK,
    input  logic           RST,
    r2s_frame_sync_if.slave bus
);

    localparam logic [ROW_W-1:0] ROW_MAX = '1;

    logic fs_edge;
    logic r2s_edge;

    sync_edge u_sync_fsync (
        .CLK       (CLK),
        .RST       (RST),
        .async_in  (bus.FSYNC_IN),
        .edge_pulse(fs_edge)
    );

    sync_edge u_sync_r2s (
        .CLK       (CLK),
        .RST       (RST),
        .async_in  (bus.R2S_IN),
        .edge_pulse(r2s_edge)
    );

    state_t             state_q, state_d;
    logic               row_strobe_q, row_strobe_d;
    logic               frame_strobe_q, frame_strobe_d;
    logic [ROW_W-1:0]   row_cnt_q, row_cnt_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               row_err_q, row_err_d;
    logic [ROW_W-1:0]   row_base;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= WAIT_FSYNC;
            row_strobe_q   <= 1'b0;
            frame_strobe_q <= 1'b0;
            row_cnt_q      <= '0;
            frame_cnt_q    <= '0;
            row_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            row_strobe_q   <= row_strobe_d;
            frame_strobe_q <= frame_strobe_d;
            row_cnt_q      <= row_cnt_d;
            frame_cnt_q    <= frame_cnt_d;
            row_err_q      <= row_err_d;
        end
    end

    // A frame sync restarts the count first, so a coincident row edge becomes row 0
    always_comb begin
        state_d        = state_q;
        row_strobe_d   = 1'b0;
        frame_strobe_d = 1'b0;
        row_cnt_d      = row_cnt_q;
        frame_cnt_d    = frame_cnt_q;
        row_err_d      = row_err_q & ~bus.ERR_CLR;
        row_base       = row_cnt_q;

        if (!bus.EN) begin
            state_d = WAIT_FSYNC;
        end else begin
            if (fs_edge) begin
                if (state_q == IN_FRAME && bus.CFG_ROWS != '0 && row_cnt_q != bus.CFG_ROWS) begin
                    row_err_d = 1'b1;
                end
                frame_strobe_d = 1'b1;
                frame_cnt_d    = frame_cnt_q + FRAME_W'(1);
                row_base       = '0;
                row_cnt_d      = '0;
                state_d        = IN_FRAME;
            end
            if (r2s_edge && (fs_edge || state_q == IN_FRAME)) begin
                row_strobe_d = (bus.CFG_ROW_FIRST <= row_base) && (row_base <= bus.CFG_ROW_LAST);
                row_cnt_d    = (row_base == ROW_MAX) ? row_base : row_base + ROW_W'(1);
            end
        end
    end

    assign bus.ROW_STROBE   = row_strobe_q;
    assign bus.FRAME_STROBE = frame_strobe_q;
    assign bus.ROW_CNT      = row_cnt_q;
    assign bus.FRAME_CNT    = frame_cnt_q;
    assign bus.ROW_ERR      = row_err_q;
    assign bus.IN_FRAME     = (state_q == IN_FRAME);

endmodule

// File: tb/tb_r2s_frame_sync.sv
// tb/tb_r2s_frame_sync.sv - directed self-checking bench for r2s_frame_sync
module tb_r2s_frame_sync;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    r2s_frame_sync_if #(.ROW_W(12), .FRAME_W(16)) if_a ();
    r2s_frame_sync_if #(.ROW_W(3),  .FRAME_W(4))  if_b ();

    r2s_frame_sync #(.ROW_W(12), .FRAME_W(16)) u_dut (
        .CLK(CLK),
        .RST(RST),
        .bus(if_a)
    );

    r2s_frame_sync #(.ROW_W(3), .FRAME_W(4)) u_small (
        .CLK(CLK),
        .RST(RST),
        .bus(if_b)
    );

    int checks = 0;
    int errors = 0;
    int a_rows = 0;
    int a_frames = 0;
    int a_mask = 0;
    int b_rows = 0;

    always @(negedge CLK) begin
        if (if_a.ROW_STROBE === 1'b1) begin
            a_rows = a_rows + 1;
            a_mask = a_mask | (1 << (int'(if_a.ROW_CNT) - 1));
        end
        if (if_a.FRAME_STROBE === 1'b1) a_frames = a_frames + 1;
        if (if_b.ROW_STROBE === 1'b1) b_rows = b_rows + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_a(input logic fs, input logic r2s);
        if_a.FSYNC_IN = fs;
        if_a.R2S_IN   = r2s;
        tick(2);
        if_a.FSYNC_IN = 1'b0;
        if_a.R2S_IN   = 1'b0;
        tick(4);
    endtask

    task automatic pulse_b(input logic fs, input logic r2s);
        if_b.FSYNC_IN = fs;
        if_b.R2S_IN   = r2s;
        tick(2);
        if_b.FSYNC_IN = 1'b0;
        if_b.R2S_IN   = 1'b0;
        tick(4);
    endtask

    task automatic test_reset;
        RST = 1'b1;
        tick(3);
        checks++;
        if ({if_a.ROW_STROBE, if_a.FRAME_STROBE, if_a.ROW_ERR, if_a.IN_FRAME} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b expected 0000",
                     {if_a.ROW_STROBE, if_a.FRAME_STROBE, if_a.ROW_ERR, if_a.IN_FRAME});
        end
        checks++;
        if (if_a.ROW_CNT !== 12'd0 || if_a.FRAME_CNT !== 16'd0) begin
            errors++;
            $display("FAIL reset_counts got row %0d frame %0d expected 0 0", if_a.ROW_CNT, if_a.FRAME_CNT);
        end
        RST = 1'b0;
        tick(5);
    endtask

    task automatic test_first_frame;
        if_a.FSYNC_IN = 1'b1;
        tick(3);
        checks++;
        if (if_a.FRAME_STROBE !== 1'b0) begin
            errors++;
            $display("FAIL fsync_early got %b expected 0", if_a.FRAME_STROBE);
        end
        tick(1);
        if_a.FSYNC_IN = 1'b0;
        checks++;
        if (if_a.FRAME_STROBE !== 1'b1 || if_a.FRAME_CNT !== 16'd1 || if_a.IN_FRAME !== 1'b1) begin
            errors++;
            $display("FAIL fsync_latency got strobe %b cnt %0d in_frame %b expected 1 1 1",
                     if_a.FRAME_STROBE, if_a.FRAME_CNT, if_a.IN_FRAME);
        end
        tick(1);
        checks++;
        if (if_a.FRAME_STROBE !== 1'b0) begin
            errors++;
            $display("FAIL fsync_one_cycle got %b expected 0", if_a.FRAME_STROBE);
        end
        tick(4);
    endtask

    task automatic test_row_gating;
        a_rows = 0;
        a_mask = 0;
        repeat (8) pulse_a(1'b0, 1'b1);
        checks++;
        if (a_rows !== 3) begin
            errors++;
            $display("FAIL gate_count got %0d expected 3", a_rows);
        end
        checks++;
        if (a_mask !== 28) begin
            errors++;
            $display("FAIL gate_rows got %0d expected 28", a_mask);
        end
        checks++;
        if (if_a.ROW_CNT !== 12'd8) begin
            errors++;
            $display("FAIL gate_row_cnt got %0d expected 8", if_a.ROW_CNT);
        end
    endtask

    task automatic test_row_err;
        if_a.CFG_ROWS = 12'd8;
        pulse_a(1'b1, 1'b0);
        checks++;
        if (if_a.ROW_ERR !== 1'b0 || if_a.FRAME_CNT !== 16'd2) begin
            errors++;
            $display("FAIL err_good_frame got err %b cnt %0d expected 0 2", if_a.ROW_ERR, if_a.FRAME_CNT);
        end
        repeat (7) pulse_a(1'b0, 1'b1);
        pulse_a(1'b1, 1'b0);
        checks++;
        if (if_a.ROW_ERR !== 1'b1 || if_a.FRAME_CNT !== 16'd3) begin
            errors++;
            $display("FAIL err_short_frame got err %b cnt %0d expected 1 3", if_a.ROW_ERR, if_a.FRAME_CNT);
        end
        if_a.ERR_CLR = 1'b1;
        tick(1);
        if_a.ERR_CLR = 1'b0;
        checks++;
        if (if_a.ROW_ERR !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got %b expected 0", if_a.ROW_ERR);
        end
        repeat (8) pulse_a(1'b0, 1'b1);
        pulse_a(1'b1, 1'b0);
        checks++;
        if (if_a.ROW_ERR !== 1'b0 || if_a.FRAME_CNT !== 16'd4) begin
            errors++;
            $display("FAIL err_full_frame got err %b cnt %0d expected 0 4", if_a.ROW_ERR, if_a.FRAME_CNT);
        end
        repeat (3) pulse_a(1'b0, 1'b1);
        if_a.FSYNC_IN = 1'b1;
        tick(2);
        if_a.FSYNC_IN = 1'b0;
        tick(1);
        if_a.ERR_CLR = 1'b1;
        tick(1);
        if_a.ERR_CLR = 1'b0;
        checks++;
        if (if_a.ROW_ERR !== 1'b1 || if_a.FRAME_STROBE !== 1'b1) begin
            errors++;
            $display("FAIL err_set_wins got err %b strobe %b expected 1 1", if_a.ROW_ERR, if_a.FRAME_STROBE);
        end
        tick(3);
        if_a.ERR_CLR = 1'b1;
        tick(1);
        if_a.ERR_CLR = 1'b0;
        if_a.CFG_ROWS = 12'd0;
    endtask

    task automatic test_simultaneous;
        if_a.CFG_ROW_FIRST = 12'd0;
        repeat (2) pulse_a(1'b0, 1'b1);
        if_a.FSYNC_IN = 1'b1;
        if_a.R2S_IN   = 1'b1;
        tick(2);
        if_a.FSYNC_IN = 1'b0;
        if_a.R2S_IN   = 1'b0;
        tick(2);
        checks++;
        if (if_a.FRAME_STROBE !== 1'b1 || if_a.ROW_STROBE !== 1'b1) begin
            errors++;
            $display("FAIL simul_strobes got frame %b row %b expected 1 1", if_a.FRAME_STROBE, if_a.ROW_STROBE);
        end
        checks++;
        if (if_a.ROW_CNT !== 12'd1 || if_a.FRAME_CNT !== 16'd6) begin
            errors++;
            $display("FAIL simul_counts got row %0d frame %0d expected 1 6", if_a.ROW_CNT, if_a.FRAME_CNT);
        end
        tick(3);
    endtask

    task automatic test_enable;
        if_a.EN = 1'b0;
        tick(1);
        checks++;
        if (if_a.IN_FRAME !== 1'b0 || if_a.ROW_CNT !== 12'd1 || if_a.FRAME_CNT !== 16'd6) begin
            errors++;
            $display("FAIL en_low got in_frame %b row %0d frame %0d expected 0 1 6",
                     if_a.IN_FRAME, if_a.ROW_CNT, if_a.FRAME_CNT);
        end
        if_a.EN = 1'b1;
        a_rows = 0;
        pulse_a(1'b0, 1'b1);
        checks++;
        if (a_rows !== 0 || if_a.ROW_CNT !== 12'd1) begin
            errors++;
            $display("FAIL wait_ignores_row got strobes %0d row %0d expected 0 1", a_rows, if_a.ROW_CNT);
        end
        pulse_a(1'b1, 1'b0);
        checks++;
        if (if_a.IN_FRAME !== 1'b1 || if_a.FRAME_CNT !== 16'd7 || if_a.ROW_CNT !== 12'd0) begin
            errors++;
            $display("FAIL en_restart got in_frame %b frame %0d row %0d expected 1 7 0",
                     if_a.IN_FRAME, if_a.FRAME_CNT, if_a.ROW_CNT);
        end
    endtask

    task automatic test_reset_midframe;
        repeat (5) pulse_a(1'b0, 1'b1);
        checks++;
        if (if_a.ROW_CNT !== 12'd5) begin
            errors++;
            $display("FAIL mid_rows got %0d expected 5", if_a.ROW_CNT);
        end
        RST = 1'b1;
        tick(1);
        checks++;
        if ({if_a.ROW_STROBE, if_a.FRAME_STROBE, if_a.ROW_ERR, if_a.IN_FRAME} !== 4'b0000 ||
            if_a.ROW_CNT !== 12'd0 || if_a.FRAME_CNT !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset got flags %b row %0d frame %0d expected 0000 0 0",
                     {if_a.ROW_STROBE, if_a.FRAME_STROBE, if_a.ROW_ERR, if_a.IN_FRAME},
                     if_a.ROW_CNT, if_a.FRAME_CNT);
        end
        RST = 1'b0;
        tick(5);
        a_rows = 0;
        repeat (3) pulse_a(1'b0, 1'b1);
        checks++;
        if (a_rows !== 0 || if_a.ROW_CNT !== 12'd0 || if_a.IN_FRAME !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_rows got strobes %0d row %0d in_frame %b expected 0 0 0",
                     a_rows, if_a.ROW_CNT, if_a.IN_FRAME);
        end
        pulse_a(1'b1, 1'b0);
        checks++;
        if (if_a.FRAME_CNT !== 16'd1 || if_a.IN_FRAME !== 1'b1 || if_a.ROW_ERR !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_frame got frame %0d in_frame %b err %b expected 1 1 0",
                     if_a.FRAME_CNT, if_a.IN_FRAME, if_a.ROW_ERR);
        end
    endtask

    task automatic test_high_at_release;
        if_a.FSYNC_IN = 1'b1;
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        a_frames = 0;
        tick(8);
        checks++;
        if (a_frames !== 0 || if_a.IN_FRAME !== 1'b0) begin
            errors++;
            $display("FAIL high_at_release got frames %0d in_frame %b expected 0 0", a_frames, if_a.IN_FRAME);
        end
        if_a.FSYNC_IN = 1'b0;
        tick(4);
        pulse_a(1'b1, 1'b0);
        checks++;
        if (a_frames !== 1 || if_a.FRAME_CNT !== 16'd1) begin
            errors++;
            $display("FAIL rearm_after_low got frames %0d cnt %0d expected 1 1", a_frames, if_a.FRAME_CNT);
        end
    endtask

    task automatic test_wrap_small;
        if_b.EN = 1'b1;
        repeat (17) pulse_b(1'b1, 1'b0);
        checks++;
        if (if_b.FRAME_CNT !== 4'd1 || if_b.IN_FRAME !== 1'b1) begin
            errors++;
            $display("FAIL frame_wrap got %0d in_frame %b expected 1 1", if_b.FRAME_CNT, if_b.IN_FRAME);
        end
        b_rows = 0;
        repeat (10) pulse_b(1'b0, 1'b1);
        checks++;
        if (if_b.ROW_CNT !== 3'd7) begin
            errors++;
            $display("FAIL row_saturate got %0d expected 7", if_b.ROW_CNT);
        end
        checks++;
        if (b_rows !== 0) begin
            errors++;
            $display("FAIL inverted_window got %0d expected 0", b_rows);
        end
    endtask

    initial begin
        if_a.EN = 1'b1;
        if_a.R2S_IN = 1'b0;
        if_a.FSYNC_IN = 1'b0;
        if_a.CFG_ROWS = 12'd0;
        if_a.CFG_ROW_FIRST = 12'd2;
        if_a.CFG_ROW_LAST = 12'd4;
        if_a.ERR_CLR = 1'b0;
        if_b.EN = 1'b0;
        if_b.R2S_IN = 1'b0;
        if_b.FSYNC_IN = 1'b0;
        if_b.CFG_ROWS = 3'd0;
        if_b.CFG_ROW_FIRST = 3'd5;
        if_b.CFG_ROW_LAST = 3'd2;
        if_b.ERR_CLR = 1'b0;

        test_reset();
        test_first_frame();
        test_row_gating();
        test_row_err();
        test_simultaneous();
        test_enable();
        test_reset_midframe();
        test_high_at_release();
        test_wrap_small();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
